// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding imem request feeding a DEPTH-entry buffer toward decode.
// Latency: request issued the cycle after IDLE sees a free slot; head visible the cycle after imem_ack.
// Backpressure: a full buffer stops new requests. Redirect flushes and drops any in-flight response.
// Optional build macro FETCH_MISALIGN_CHECK_EN adds the sticky fetch_misalign output.
module instr_fetch #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] pc_next,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        fetch_misalign
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] req_addr_q, req_addr_d;
    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    cnt_t        count_q, count_d;
    entry_t      fifo_q [DEPTH];
    entry_t      head;

    logic        push;
    logic        pop;
    logic        halt;
    logic [31:0] target;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    // A misaligned redirect latches the error until reset and blocks further fetches.
    assign misalign_d     = misalign_q | (redirect & (redirect_pc[1:0] != 2'b00));
    assign halt           = misalign_q;
    assign target         = redirect_pc;
    assign fetch_misalign = misalign_q;

    // Sticky misalign flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`else
    logic unused_redirect_lsbs;

    // Without the check the low target bits are forced to word alignment.
    assign halt                 = 1'b0;
    assign target               = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

    assign head       = fifo_q[rd_ptr_q];
    assign inst       = head.inst;
    assign inst_pc    = head.pc;
    assign inst_valid = (count_q != '0);
    assign imem_req   = (state_q != IDLE);
    assign imem_addr  = req_addr_q;

    // A pop in a redirect cycle is void: the flush wins.
    assign pop = inst_valid & inst_ready & ~redirect;

    // Next-state logic; a response that arrives with or after a redirect is never pushed.
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!redirect && !halt && (count_q != cnt_t'(DEPTH))) begin
                    req_addr_d = pc;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    state_d = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            DROP: begin
                // The ack retires the stale request even if another redirect arrives with it;
                // waiting for a second ack would hang the fetch unit.
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer pointer and occupancy update; redirect clears everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    // Next PC toward program_counter: redirect, then advance on an accepted fetch, else hold.
    always_comb begin
        pc_next = pc;
        if (reset) begin
            pc_next = pc;
        end else if (redirect) begin
            pc_next = target;
        end else if (push) begin
            pc_next = pc + 32'd4;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Buffer storage; entries are only observed while counted, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {req_addr_q, imem_rdata};
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_req_q [$];
    logic [63:0] exp_inst_q [$];
    logic        prev_req = 1'b0;
    logic [31:0] nxt;

    always #5 clk = ~clk;

    instr_fetch #(.DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .pc_next    (pc_next),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misalign(fetch_misalign)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: new requests and decode handshakes are checked against the scoreboards.
    always @(negedge clk) begin
        if (imem_req && !prev_req) begin
            if (exp_req_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
            end else begin
                check("req_addr", imem_addr, exp_req_q.pop_front());
            end
        end
        if (inst_valid && inst_ready && !redirect) begin
            if (exp_inst_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_inst: got pc %h inst %h expected none", inst_pc, inst);
            end else begin
                check64("inst_pop", {inst_pc, inst}, exp_inst_q.pop_front());
            end
        end
        prev_req = imem_req;
    end

    task automatic mid();
        @(negedge clk);
    endtask

    // Advance one cycle; the bench plays program_counter by loading pc_next.
    task automatic adv();
        nxt = pc_next;
        @(posedge clk);
        #1;
        if (!reset) pc = nxt;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        redirect   = 1'b0;
    endtask

    // One complete fetch starting in IDLE: 1 idle cycle, 2 wait cycles, ack on the third request cycle.
    task automatic serve(input logic [31:0] addr, input logic [31:0] exp_next, input bit idle_ack);
        exp_req_q.push_back(addr);
        exp_inst_q.push_back({addr, mem_word(addr)});
        if (idle_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hBAD0_BAD0;
        end
        mid(); check("idle_pc_next", pc_next, addr); adv();
        repeat (2) begin
            mid(); check("wait_req", {31'd0, imem_req}, 32'd1); adv();
        end
        imem_ack   = 1'b1;
        imem_rdata = mem_word(addr);
        mid(); check("ack_pc_next", pc_next, exp_next); adv();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pc = 32'h20; redirect = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b1;

        // Reset state
        mid(); check("rst_pc_next", pc_next, 32'h20); adv();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        mid(); adv();
        reset = 1'b0; pc = 32'h0;

        // Sequential fetch 0, 4 with decode always ready
        serve(32'h0, 32'h4, 1'b0);
        serve(32'h4, 32'h8, 1'b0);
        exp_req_q.push_back(32'h8);
        mid(); check("hold_pc_next", pc_next, 32'h8); adv();

        // Reset while waiting on 0x8; ack in the first post-reset cycle must be ignored
        reset = 1'b1;
        mid(); check("rst_mid_pc_next", pc_next, 32'h8); adv();
        check("rst_mid_req", {31'd0, imem_req}, 32'd0);
        reset = 1'b0; pc = 32'h0; inst_ready = 1'b0;

        // Buffer fills with 0, 4 while decode stalls
        serve(32'h0, 32'h4, 1'b1);
        serve(32'h4, 32'h8, 1'b0);
        repeat (3) begin
            mid();
            check("full_req", {31'd0, imem_req}, 32'd0);
            check("full_valid", {31'd0, inst_valid}, 32'd1);
            check("full_pc_next", pc_next, 32'h8);
            adv();
        end
        inst_ready = 1'b1;
        exp_req_q.push_back(32'h8);
        mid(); adv();
        mid(); adv();
        mid(); check("resume_req", {31'd0, imem_req}, 32'd1); adv();

        // Redirect while waiting on 0x8 without ack -> drop
        redirect = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
        redirect_pc = 32'h100;
`else
        redirect_pc = 32'h102;
`endif
        mid(); check("redir_pc_next", pc_next, 32'h100); adv();
        check("drop_valid", {31'd0, inst_valid}, 32'd0);
        mid();
        check("drop_req", {31'd0, imem_req}, 32'd1);
        check("drop_addr", imem_addr, 32'h8);
        adv();
        imem_ack = 1'b1; imem_rdata = mem_word(32'h8);
        mid(); check("drop_ack_pc_next", pc_next, 32'h100); adv();
        check("after_drop_valid", {31'd0, inst_valid}, 32'd0);
        serve(32'h100, 32'h104, 1'b0);

        // Redirect in DROP stays in DROP; then redirect coinciding with ack of 0xC
        exp_req_q.push_back(32'h104);
        mid(); adv();
        redirect = 1'b1; redirect_pc = 32'hC;
        mid(); check("redir_c_pc_next", pc_next, 32'hC); adv();
        redirect = 1'b1; redirect_pc = 32'hC;
        mid();
        check("drop2_req", {31'd0, imem_req}, 32'd1);
        check("drop2_addr", imem_addr, 32'h104);
        adv();
        imem_ack = 1'b1; imem_rdata = mem_word(32'h104);
        mid(); adv();
        exp_req_q.push_back(32'hC);
        mid(); check("idle_c_pc_next", pc_next, 32'hC); adv();
        mid(); adv();
        mid(); adv();
        imem_ack = 1'b1; imem_rdata = mem_word(32'hC);
        redirect = 1'b1; redirect_pc = 32'h40;
        mid(); check("same_cycle_pc_next", pc_next, 32'h40); adv();
        check("same_cycle_valid", {31'd0, inst_valid}, 32'd0);
        serve(32'h40, 32'h44, 1'b0);

        // Redirect while head is valid: flushed, pop void
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        exp_inst_q.delete();
        mid();
        check("pre_flush_valid", {31'd0, inst_valid}, 32'd1);
        check("wrap_redir_pc_next", pc_next, 32'hFFFF_FFFC);
        adv();
        check("flush_valid", {31'd0, inst_valid}, 32'd0);

        // PC wrap at top of address space
        serve(32'hFFFF_FFFC, 32'h0, 1'b0);
        exp_req_q.push_back(32'h0);
        mid(); adv();

`ifdef FETCH_MISALIGN_CHECK_EN
        redirect = 1'b1; redirect_pc = 32'h102;
        mid(); check("mis_pc_next", pc_next, 32'h102); adv();
        check("mis_flag", {31'd0, fetch_misalign}, 32'd1);
        check("mis_drop_req", {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = mem_word(32'h0);
        mid(); adv();
        repeat (4) begin
            mid();
            check("mis_req", {31'd0, imem_req}, 32'd0);
            check("mis_sticky", {31'd0, fetch_misalign}, 32'd1);
            adv();
        end
        reset = 1'b1;
        mid(); adv();
        check("mis_clear", {31'd0, fetch_misalign}, 32'd0);
`else
        reset = 1'b1;
        mid(); adv();
`endif
        mid(); adv();
        check("req_queue_empty", exp_req_q.size(), 32'd0);
        check("inst_queue_empty", exp_inst_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
